// File: rtl/d_regfile_mp_pkg.sv
// Shared constants, types and elaboration helpers for the multi-port register file.
// Pure declarations: no logic, no latency, no flow control.
package d_reg_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REG_ZERO = 0;
    localparam int MAX_AW   = 6;

    typedef logic [MAX_AW-1:0] reg_addr_t;

    function automatic int d_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i <= MAX_AW; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Non power-of-two register counts leave holes at the top of the address space.
    function automatic logic in_range(input logic [31:0] a, input int n);
        return a < 32'(n);
    endfunction

endpackage

// File: rtl/d_regfile_mp_if.sv
// Decode/writeback-facing bundle of the register file: read, write, issue and debug ports.
// Plain wires; timing and flow control belong to the modules on either side.
interface d_regfile_mp_if
    import d_reg_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = d_clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, dbg_addr,
        input  rd_data, rd_busy, dbg_data
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, dbg_addr,
        output rd_data, rd_busy, dbg_data
    );

endinterface

// File: rtl/d_regfile_mp_bypass_mux.sv
// Per-read-port forwarding: picks the highest-index same-cycle write over the stored word.
// Purely combinational, zero latency; no backpressure.
module d_reg_bypass_mux #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]       rd_addr_i,
    input  logic [XLEN-1:0]     stor_dat_i,
    input  logic                stor_busy_i,
    input  logic [NWR-1:0]      wr_acc_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0]     rd_data_o,
    output logic                rd_busy_o
);

    logic            hit;
    logic [XLEN-1:0] fwd;

    // Ascending scan so the last match, the highest write port, wins.
    always_comb begin
        hit = 1'b0;
        fwd = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_acc_i[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i)) begin
                hit = 1'b1;
                fwd = wr_data_i[j*XLEN +: XLEN];
            end
        end
    end

    assign rd_data_o = ((BYPASS != 0) && hit) ? fwd : stor_dat_i;
    assign rd_busy_o = stor_busy_i & ~((BYPASS != 0) & hit);

endmodule

// File: rtl/d_regfile_mp.sv
// Multi-port register file with busy scoreboard; reads combinational, writes/issues take one edge.
// No backpressure: every accepted write and issue lands on the next clock edge.
module d_regfile_mp
    import d_reg_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    d_regfile_mp_if.slave rf
);

    localparam int AW = d_clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NWR-1:0]   wr_acc;
    logic             iss_acc;

    // Addresses that hold real, writable state: in range and not the hard-wired zero.
    function automatic logic live_addr(input logic [AW-1:0] a);
        return in_range(32'(a), NREGS) && !((ZERO_REG != 0) && (a == AW'(REG_ZERO)));
    endfunction

    // Gating with rst_n keeps writes out of both storage and the bypass while held in reset.
    for (genvar j = 0; j < NWR; j++) begin : g_wr
        assign wr_acc[j] = rst_n & rf.wr_en[j] & live_addr(rf.wr_addr[j*AW +: AW]);
    end

    assign iss_acc = rst_n & rf.iss_en & live_addr(rf.iss_addr);

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_acc[j]) begin
                regs_d[rf.wr_addr[j*AW +: AW]] = rf.wr_data[j*XLEN +: XLEN];
                busy_d[rf.wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        // Issue applied after writeback clears: the newer producer keeps the register busy.
        if (iss_acc) begin
            busy_d[rf.iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] stor_dat;
        logic            stor_busy;

        assign addr      = rf.rd_addr[i*AW +: AW];
        assign stor_dat  = live_addr(addr) ? regs_q[addr] : '0;
        assign stor_busy = live_addr(addr) & busy_q[addr];

        d_reg_bypass_mux #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NWR    (NWR),
            .BYPASS (BYPASS)
        ) u_mux (
            .rd_addr_i   (addr),
            .stor_dat_i  (stor_dat),
            .stor_busy_i (stor_busy),
            .wr_acc_i    (wr_acc),
            .wr_addr_i   (rf.wr_addr),
            .wr_data_i   (rf.wr_data),
            .rd_data_o   (rf.rd_data[i*XLEN +: XLEN]),
            .rd_busy_o   (rf.rd_busy[i])
        );
    end

    assign rf.dbg_data = live_addr(rf.dbg_addr) ? regs_q[rf.dbg_addr] : '0;

endmodule
